// File: rtl/operand_fetch_pkg.sv
// Shared core constants, operand-stage payload type and the forwarding/hazard helpers.
package operand_fetch_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int RF_AW  = 64;

    typedef logic [XLEN-1:0]   xword_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        xword_t   op1;
        xword_t   op2;
        xword_t   pc;
        xword_t   imm;
        logic     rd_en;
        reg_idx_t rd_addr;
    } ex_payload_t;

    // x0 always reads zero; otherwise a same-cycle writeback beats the stale regfile value.
    function automatic xword_t resolve_operand(
        input logic     src_en,
        input reg_idx_t idx,
        input logic     wb_en,
        input reg_idx_t wb_addr,
        input xword_t   wb_data,
        input xword_t   rf_data
    );
        if (!src_en || idx == '0)
            return '0;
        else if (wb_en && wb_addr == idx)
            return wb_data;
        else
            return rf_data;
    endfunction

    function automatic logic src_hazard(
        input logic            src_en,
        input reg_idx_t        idx,
        input logic [NREG-1:0] busy,
        input logic            wb_en,
        input reg_idx_t        wb_addr,
        input logic            ex_valid,
        input logic            ex_rd_en,
        input reg_idx_t        ex_rd_addr
    );
        logic pending;
        logic in_flight;
        pending   = busy[idx] && !(wb_en && wb_addr == idx);
        in_flight = ex_valid && ex_rd_en && ex_rd_addr == idx;
        return src_en && idx != '0 && (pending || in_flight);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-to-operand-fetch and operand-fetch-to-execute handshake bundle.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic     id_valid;
    logic     id_ready;
    logic     id_rs1_en;
    logic     id_rs2_en;
    logic     id_rd_en;
    reg_idx_t id_rs1_addr;
    reg_idx_t id_rs2_addr;
    reg_idx_t id_rd_addr;
    xword_t   id_pc;
    xword_t   id_imm;

    logic     ex_valid;
    logic     ex_ready;
    xword_t   ex_op1;
    xword_t   ex_op2;
    xword_t   ex_pc;
    xword_t   ex_imm;
    logic     ex_rd_en;
    reg_idx_t ex_rd_addr;

    // master is the surrounding pipeline (decode + execute), slave is operand_fetch.
    modport master (
        output id_valid, id_rs1_en, id_rs2_en, id_rd_en,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_pc, id_imm, ex_ready,
        input  id_ready, ex_valid, ex_op1, ex_op2, ex_pc, ex_imm, ex_rd_en, ex_rd_addr
    );

    modport slave (
        input  id_valid, id_rs1_en, id_rs2_en, id_rd_en,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_pc, id_imm, ex_ready,
        output id_ready, ex_valid, ex_op1, ex_op2, ex_pc, ex_imm, ex_rd_en, ex_rd_addr
    );

endinterface

// File: rtl/operand_fetch_gpr_scoreboard.sv
// Per-register busy bits for results handed to execute but not yet written back.
module gpr_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  reg_idx_t        set_addr,
    input  logic            clr_en,
    input  reg_idx_t        clr_addr,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_next;

    // Set is applied after clear so a new producer of the same register wins; x0 is never tracked.
    always_comb begin
        set_mask  = set_en ? (NREG'(1) << set_addr) : '0;
        clr_mask  = clr_en ? (NREG'(1) << clr_addr) : '0;
        busy_next = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read, writeback forwarding, RAW hazard stall and one output register.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    operand_fetch_if.slave   bus,
    output logic             rs1_en,
    output logic             rs2_en,
    output logic [RF_AW-1:0] rs1_addr,
    output logic [RF_AW-1:0] rs2_addr,
    input  xword_t           rs1_data,
    input  xword_t           rs2_data,
    input  logic             wb_en,
    input  reg_idx_t         wb_addr,
    input  xword_t           wb_data,
    input  logic             flush,
    output logic [31:0]      stall_cnt
);

    logic            ex_valid_q;
    ex_payload_t     ex_q;
    ex_payload_t     ex_d;
    logic [NREG-1:0] busy;
    logic            haz1;
    logic            haz2;
    logic            hazard;
    logic            id_ready;
    logic            capture;
    logic            handoff;

    assign rs1_en   = bus.id_rs1_en;
    assign rs2_en   = bus.id_rs2_en;
    assign rs1_addr = RF_AW'(bus.id_rs1_addr);
    assign rs2_addr = RF_AW'(bus.id_rs2_addr);

    always_comb begin
        haz1 = src_hazard(bus.id_rs1_en, bus.id_rs1_addr, busy, wb_en, wb_addr,
                          ex_valid_q, ex_q.rd_en, ex_q.rd_addr);
        haz2 = src_hazard(bus.id_rs2_en, bus.id_rs2_addr, busy, wb_en, wb_addr,
                          ex_valid_q, ex_q.rd_en, ex_q.rd_addr);
        hazard = haz1 || haz2;
    end

    assign id_ready = (!ex_valid_q || bus.ex_ready) && !hazard && !flush && !reset;
    assign capture  = bus.id_valid && id_ready;
    // A flushed entry is squashed, so it must not mark its destination busy.
    assign handoff  = ex_valid_q && bus.ex_ready && ex_q.rd_en && ex_q.rd_addr != '0 && !flush;

    always_comb begin
        ex_d.op1     = resolve_operand(bus.id_rs1_en, bus.id_rs1_addr, wb_en, wb_addr, wb_data, rs1_data);
        ex_d.op2     = resolve_operand(bus.id_rs2_en, bus.id_rs2_addr, wb_en, wb_addr, wb_data, rs2_data);
        ex_d.pc      = bus.id_pc;
        ex_d.imm     = bus.id_imm;
        ex_d.rd_en   = bus.id_rd_en;
        ex_d.rd_addr = bus.id_rd_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (capture) begin
            ex_valid_q <= 1'b1;
            ex_q       <= ex_d;
        end else if (ex_valid_q && bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.id_valid && hazard && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    gpr_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (handoff),
        .set_addr (ex_q.rd_addr),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .busy     (busy)
    );

    assign bus.id_ready   = id_ready;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_op1     = ex_q.op1;
    assign bus.ex_op2     = ex_q.op2;
    assign bus.ex_pc      = ex_q.pc;
    assign bus.ex_imm     = ex_q.imm;
    assign bus.ex_rd_en   = ex_q.rd_en;
    assign bus.ex_rd_addr = ex_q.rd_addr;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding, x0, RAW stall, backpressure, flush and reset.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rs1_en;
    logic        rs2_en;
    logic [63:0] rs1_addr;
    logic [63:0] rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;
    logic [31:0] stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    operand_fetch_if bus_if ();

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .rs1_en    (rs1_en),
        .rs2_en    (rs2_en),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid,
                                 input logic s1_en, input logic [4:0] s1,
                                 input logic s2_en, input logic [4:0] s2,
                                 input logic d_en,  input logic [4:0] d,
                                 input logic [63:0] pc, input logic [63:0] imm);
        bus_if.id_valid    = valid;
        bus_if.id_rs1_en   = s1_en;
        bus_if.id_rs1_addr = s1;
        bus_if.id_rs2_en   = s2_en;
        bus_if.id_rs2_addr = s2;
        bus_if.id_rd_en    = d_en;
        bus_if.id_rd_addr  = d;
        bus_if.id_pc       = pc;
        bus_if.id_imm      = imm;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 64'h0);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        wb_en    = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 64'h0;
        rs1_data = 64'h0;
        rs2_data = 64'h0;
        bus_if.ex_ready = 1'b1;
        idle();
        tick();
        tick();
        checkOutput("reset_id_ready", 64'(bus_if.id_ready), 64'h0);
        checkOutput("reset_ex_valid", 64'(bus_if.ex_valid), 64'h0);
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'h0);
        checkOutput("reset_busy", 64'(dut.u_scoreboard.busy), 64'h0);
        reset = 1'b0;

        // Same-cycle writeback to x5 overrides the stale regfile value.
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd10, 64'h1000, 64'h4);
        rs1_data = 64'h11;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h22;
        #1;
        checkOutput("fwd_id_ready", 64'(bus_if.id_ready), 64'h1);
        checkOutput("fwd_rs1_en", 64'(rs1_en), 64'h1);
        checkOutput("fwd_rs1_addr", rs1_addr, 64'h5);
        checkOutput("fwd_rs2_en", 64'(rs2_en), 64'h0);
        tick();
        idle();
        wb_en = 1'b0;
        checkOutput("fwd_ex_valid", 64'(bus_if.ex_valid), 64'h1);
        checkOutput("fwd_ex_op1", bus_if.ex_op1, 64'h22);
        checkOutput("fwd_ex_op2", bus_if.ex_op2, 64'h0);
        checkOutput("fwd_ex_pc", bus_if.ex_pc, 64'h1000);
        checkOutput("fwd_ex_imm", bus_if.ex_imm, 64'h4);
        checkOutput("fwd_ex_rd_en", 64'(bus_if.ex_rd_en), 64'h1);
        checkOutput("fwd_ex_rd_addr", 64'(bus_if.ex_rd_addr), 64'hA);
        tick();
        checkOutput("handoff_ex_valid", 64'(bus_if.ex_valid), 64'h0);
        checkOutput("handoff_busy_x10", 64'(dut.u_scoreboard.busy), 64'h400);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 64'h0;
        tick();
        wb_en = 1'b0;
        checkOutput("wb_clear_x10", 64'(dut.u_scoreboard.busy), 64'h0);

        // RAW on x3: stall until writeback, then capture the written value.
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 64'h2000, 64'h0);
        tick();
        idle();
        tick();
        checkOutput("raw_busy_x3", 64'(dut.u_scoreboard.busy), 64'h8);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 64'h2004, 64'h8);
        rs2_data = 64'h99;
        #1;
        checkOutput("raw_id_ready_0", 64'(bus_if.id_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("raw_id_ready_stall", 64'(bus_if.id_ready), 64'h0);
        end
        checkOutput("raw_stall_cnt", 64'(stall_cnt), 64'h3);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h3333;
        #1;
        checkOutput("raw_id_ready_wb", 64'(bus_if.id_ready), 64'h1);
        tick();
        idle();
        wb_en = 1'b0;
        checkOutput("raw_ex_valid", 64'(bus_if.ex_valid), 64'h1);
        checkOutput("raw_ex_op2", bus_if.ex_op2, 64'h3333);
        checkOutput("raw_ex_pc", bus_if.ex_pc, 64'h2004);
        checkOutput("raw_stall_hold", 64'(stall_cnt), 64'h3);
        checkOutput("raw_busy_clear", 64'(dut.u_scoreboard.busy), 64'h0);

        // Execute backpressure holds the payload and blocks new captures.
        bus_if.ex_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 64'h3000, 64'h0);
        rs1_data = 64'h55;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_id_ready", 64'(bus_if.id_ready), 64'h0);
            tick();
            checkOutput("bp_ex_valid", 64'(bus_if.ex_valid), 64'h1);
            checkOutput("bp_ex_op2", bus_if.ex_op2, 64'h3333);
            checkOutput("bp_ex_pc", bus_if.ex_pc, 64'h2004);
        end
        checkOutput("bp_stall_cnt", 64'(stall_cnt), 64'h3);
        bus_if.ex_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(bus_if.id_ready), 64'h1);
        tick();
        idle();
        checkOutput("bp_new_op1", bus_if.ex_op1, 64'h55);
        checkOutput("bp_new_pc", bus_if.ex_pc, 64'h3000);
        tick();
        checkOutput("bp_drain", 64'(bus_if.ex_valid), 64'h0);

        // x0 source reads zero even with regfile data and a writeback aimed at x0.
        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 64'h4000, 64'h0);
        rs1_data = 64'hDEAD;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hBEEF;
        tick();
        idle();
        wb_en = 1'b0;
        checkOutput("x0_ex_valid", 64'(bus_if.ex_valid), 64'h1);
        checkOutput("x0_ex_op1", bus_if.ex_op1, 64'h0);
        tick();
        checkOutput("x0_busy", 64'(dut.u_scoreboard.busy), 64'h0);

        // Flush squashes an rd=x7 entry and blocks the capture in the same cycle.
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 64'h5000, 64'h0);
        tick();
        checkOutput("flush_pre_valid", 64'(bus_if.ex_valid), 64'h1);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'h5100, 64'h0);
        flush = 1'b1;
        #1;
        checkOutput("flush_id_ready", 64'(bus_if.id_ready), 64'h0);
        tick();
        flush = 1'b0;
        checkOutput("flush_ex_valid", 64'(bus_if.ex_valid), 64'h0);
        checkOutput("flush_busy_x7", 64'(dut.u_scoreboard.busy), 64'h0);
        applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 64'h5200, 64'h0);
        rs1_data = 64'h77;
        #1;
        checkOutput("flush_x7_ready", 64'(bus_if.id_ready), 64'h1);
        tick();
        idle();
        checkOutput("flush_next_op1", bus_if.ex_op1, 64'h77);
        checkOutput("flush_next_pc", bus_if.ex_pc, 64'h5200);
        tick();
        checkOutput("flush_stall_cnt", 64'(stall_cnt), 64'h3);

        // Reset mid-stall with x3 and x7 busy and five stall cycles counted.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst2_stall_cnt", 64'(stall_cnt), 64'h0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 64'h6000, 64'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 64'h6004, 64'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 64'h6008, 64'h0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("mid_busy", 64'(dut.u_scoreboard.busy), 64'h88);
        checkOutput("mid_stall_cnt", 64'(stall_cnt), 64'h5);
        checkOutput("mid_ex_pc", bus_if.ex_pc, 64'h6004);
        reset = 1'b1;
        flush = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
        #1;
        checkOutput("rst_id_ready", 64'(bus_if.id_ready), 64'h0);
        tick();
        checkOutput("rst_ex_valid", 64'(bus_if.ex_valid), 64'h0);
        checkOutput("rst_ex_op1", bus_if.ex_op1, 64'h0);
        checkOutput("rst_ex_pc", bus_if.ex_pc, 64'h0);
        checkOutput("rst_ex_rd_en", 64'(bus_if.ex_rd_en), 64'h0);
        checkOutput("rst_ex_rd_addr", 64'(bus_if.ex_rd_addr), 64'h0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        checkOutput("rst_busy", 64'(dut.u_scoreboard.busy), 64'h0);
        reset = 1'b0;
        flush = 1'b0;
        wb_en = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
